// File: rtl/fpga_led_status_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpga_led_status_ctrl
// Brief    : NUM_CH moded LED channels (off/on/heartbeat/event-stretch) plus an
//            optional MSB-first blink-code engine, enabled by macro LED_CODE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fpga_led_status_ctrl #(
   parameter int NUM_CH    = 4,
   parameter int CNT_WIDTH = 27,
   parameter int STRETCH_W = 20,
   parameter int CODE_W    = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [2*NUM_CH-1:0]   mode_i,
   input  logic [NUM_CH-1:0]     event_i,
   output logic [NUM_CH-1:0]     led_o,
   input  logic                  code_valid_i,
   input  logic [CODE_W-1:0]     code_i,
   output logic                  code_led_o,
   output logic                  code_busy_o,
   output logic                  code_done_o
);

   logic [CNT_WIDTH-1:0] hb_cnt;
   logic                 tick;
   logic [STRETCH_W-1:0] st_cnt [NUM_CH];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) hb_cnt <= '0;
      else       hb_cnt <= hb_cnt + 1'b1;
   end

   // One code unit elapses each time the low CNT_WIDTH-3 bits roll over.
   assign tick = &hb_cnt[CNT_WIDTH-4:0];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int c = 0; c < NUM_CH; c++) st_cnt[c] <= '0;
         led_o <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (event_i[c])              st_cnt[c] <= '1;
            else if (st_cnt[c] != '0)    st_cnt[c] <= st_cnt[c] - 1'b1;
            case (mode_i[2*c +: 2])
               2'b00:   led_o[c] <= 1'b0;
               2'b01:   led_o[c] <= 1'b1;
               2'b10:   led_o[c] <= hb_cnt[CNT_WIDTH-1];
               default: led_o[c] <= (st_cnt[c] != '0);
            endcase
         end
      end
   end

`ifdef LED_CODE_EN
   localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_ON, S_OFF} state_t;

   state_t            state;
   logic [CODE_W-1:0] shreg;
   logic [IDX_W-1:0]  bit_idx;
   logic [1:0]        unit_cnt;
   logic              cur_bit;
   logic              next_bit;

   assign cur_bit  = shreg[bit_idx];
   assign next_bit = shreg[bit_idx - 1'b1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         shreg       <= '0;
         bit_idx     <= '0;
         unit_cnt    <= '0;
         code_led_o  <= 1'b0;
         code_busy_o <= 1'b0;
         code_done_o <= 1'b0;
      end else begin
         code_done_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (code_valid_i) begin
                  shreg       <= code_i;
                  bit_idx     <= IDX_W'(CODE_W - 1);
                  state       <= S_SYNC;
                  code_busy_o <= 1'b1;
               end
            end
            S_SYNC: begin
               if (tick) begin
                  state      <= S_ON;
                  unit_cnt   <= cur_bit ? 2'd3 : 2'd1;
                  code_led_o <= 1'b1;
               end
            end
            S_ON: begin
               if (tick) begin
                  if (unit_cnt == 2'd1) begin
                     // Off-time fills the rest of the 4-unit bit slot.
                     state      <= S_OFF;
                     unit_cnt   <= cur_bit ? 2'd1 : 2'd3;
                     code_led_o <= 1'b0;
                  end else begin
                     unit_cnt <= unit_cnt - 1'b1;
                  end
               end
            end
            S_OFF: begin
               if (tick) begin
                  if (unit_cnt == 2'd1) begin
                     if (bit_idx == '0) begin
                        state       <= S_IDLE;
                        code_busy_o <= 1'b0;
                        code_done_o <= 1'b1;
                     end else begin
                        bit_idx    <= bit_idx - 1'b1;
                        state      <= S_ON;
                        unit_cnt   <= next_bit ? 2'd3 : 2'd1;
                        code_led_o <= 1'b1;
                     end
                  end else begin
                     unit_cnt <= unit_cnt - 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
`else
   logic unused_code;
   assign unused_code = ^{code_valid_i, code_i, tick};
   assign code_led_o  = 1'b0;
   assign code_busy_o = 1'b0;
   assign code_done_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpga_led_status_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpga_led_status_ctrl
// Brief    : Randomised + directed bench for fpga_led_status_ctrl against a
//            cycle-index reference model (code checks follow LED_CODE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpga_led_status_ctrl;
   localparam int NUM_CH    = 4;
   localparam int CNT_WIDTH = 6;
   localparam int STRETCH_W = 4;
   localparam int CODE_W    = 8;
   localparam int UNIT      = 1 << (CNT_WIDTH - 3);
   localparam int HB_P      = 1 << CNT_WIDTH;
   localparam int ST_LEN    = (1 << STRETCH_W) - 1;
   localparam int SLOT      = 4 * UNIT;

   logic                clk = 1'b0;
   logic                rst_i = 1'b1;
   logic [2*NUM_CH-1:0] mode_i = '0;
   logic [NUM_CH-1:0]   event_i = '0;
   logic [NUM_CH-1:0]   led_o;
   logic                code_valid_i = 1'b0;
   logic [CODE_W-1:0]   code_i = '0;
   logic                code_led_o, code_busy_o, code_done_o;

   fpga_led_status_ctrl #(
      .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .STRETCH_W(STRETCH_W), .CODE_W(CODE_W)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .event_i(event_i), .led_o(led_o),
      .code_valid_i(code_valid_i), .code_i(code_i), .code_led_o(code_led_o),
      .code_busy_o(code_busy_o), .code_done_o(code_done_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: n counts clock edges since reset release.
   int                n;
   int                last_ev [NUM_CH];
   bit                active;
   int                t0, cend;
   logic [CODE_W-1:0] cval;
   bit                exp_done_now;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
      end
   endtask

   task automatic reset_model();
      n = 0;
      for (int c = 0; c < NUM_CH; c++) last_ev[c] = -1000;
      active = 0;
      exp_done_now = 0;
   endtask

   // One clock edge: inputs present at the edge are read back after it.
   task automatic step();
      logic [NUM_CH-1:0] e_led;
      logic              e_cled, e_busy, e_done, hb, str, b;
      int                m, j, off;
      @(posedge clk);
      #1;
      n++;
      hb = (((n - 1) % HB_P) >= HB_P / 2);
      for (int c = 0; c < NUM_CH; c++) begin
         m   = int'(mode_i[2*c +: 2]);
         str = (last_ev[c] >= n - ST_LEN);
         case (m)
            0:       e_led[c] = 1'b0;
            1:       e_led[c] = 1'b1;
            2:       e_led[c] = hb;
            default: e_led[c] = str;
         endcase
         if (event_i[c]) last_ev[c] = n;
      end
`ifdef LED_CODE_EN
      if (code_valid_i && !(active && n <= cend)) begin
         active = 1;
         t0     = (n / UNIT + 1) * UNIT;
         cend   = t0 + SLOT * CODE_W;
         cval   = code_i;
      end
`endif
      e_busy = active && (n < cend);
      e_done = active && (n == cend);
      e_cled = 1'b0;
      if (active && n >= t0 && n < cend) begin
         j      = (n - t0) / SLOT;
         off    = (n - t0) % SLOT;
         b      = cval[CODE_W - 1 - j];
         e_cled = (off < (b ? 3 * UNIT : UNIT));
      end
      exp_done_now = e_done;
      chk("led", 32'(led_o), 32'(e_led));
      chk("code_led", 32'(code_led_o), 32'(e_cled));
      chk("code_busy", 32'(code_busy_o), 32'(e_busy));
      chk("code_done", 32'(code_done_o), 32'(e_done));
   endtask

   task automatic run(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_led"}, 32'(led_o), 32'd0);
      chk({tag, "_code_led"}, 32'(code_led_o), 32'd0);
      chk({tag, "_busy"}, 32'(code_busy_o), 32'd0);
      chk({tag, "_done"}, 32'(code_done_o), 32'd0);
   endtask

   initial begin
      reset_model();
      mode_i = {2'b11, 2'b01, 2'b00, 2'b10};
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_i = 1'b0;

      // Heartbeat, static modes and stretch with a retrigger 10 cycles later.
      run(5);
      event_i[3] = 1'b1; step(); event_i[3] = 1'b0;
      run(30);
      event_i[3] = 1'b1; step(); event_i[3] = 1'b0;
      run(9);
      event_i[3] = 1'b1; step(); event_i[3] = 1'b0;
      while (n < 99) step();
      mode_i = {2'b11, 2'b00, 2'b01, 2'b10};
      run(100);

      // Blink code A5, a stray request while busy, then back-to-back after done.
      code_valid_i = 1'b1; code_i = 8'hA5; step(); code_valid_i = 1'b0;
      run(40);
      code_valid_i = 1'b1; code_i = 8'h3C; step(); code_valid_i = 1'b0;
      for (int i = 0; i < 400 && !exp_done_now; i++) step();
      code_valid_i = 1'b1; code_i = 8'h5E; step(); code_valid_i = 1'b0;
      run(300);

      // Randomised traffic on modes, events and code requests.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 49) == 0) mode_i = 8'($urandom);
         for (int c = 0; c < NUM_CH; c++) event_i[c] = ($urandom_range(0, 9) == 0);
         code_valid_i = ($urandom_range(0, 59) == 0);
         code_i       = 8'($urandom);
         step();
      end
      event_i = '0;
      code_valid_i = 1'b0;
      run(20);

      // Reset during bit 3 of a display, then a fresh display from the MSB.
      mode_i = {2'b11, 2'b01, 2'b01, 2'b01};
      code_valid_i = 1'b1; code_i = 8'h96; step(); code_valid_i = 1'b0;
      run(150);
      #2;
      rst_i = 1'b1;
      #1;
      check_all_zero("async_rst");
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("held_rst");
      @(negedge clk);
      rst_i = 1'b0;
      reset_model();
      run(3);
      code_valid_i = 1'b1; code_i = 8'hC3; step(); code_valid_i = 1'b0;
      run(300);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
